// File: rtl/rf_ifm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rf_ifm_pkg
// Brief    : Shared defaults and pointer-width helpers for the IFM row ring.
// Revision : 1.0 - initial release
// ============================================================================
package rf_ifm_pkg;

    localparam int unsigned DEF_COL   = 8;
    localparam int unsigned DEF_DW    = 8;
    localparam int unsigned DEF_DEPTH = 4;

    // Pointer width: address bits plus one wrap bit.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    // Address width into the row storage (at least one bit).
    function automatic int unsigned addr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rf_ifm_mem.sv
`default_nettype none
// ============================================================================
// Module   : rf_ifm_mem
// Brief    : Row storage, one synchronous write port and one asynchronous
//            read port. Contents are not reset.
// Revision : 1.0 - initial release
// ============================================================================
module rf_ifm_mem #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Write the offered row on the rising edge when enabled.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/rf_ifm_ring.sv
`default_nettype none
// ============================================================================
// Module   : rf_ifm_ring
// Brief    : Input-feature-map row ring buffer with a reuse window. Rows are
//            popped into a registered output; a mark/rewind/release window
//            lets the consumer replay rows without freeing them.
// Revision : 1.0 - initial release
// ============================================================================
module rf_ifm_ring
    import rf_ifm_pkg::*;
#(
    parameter int unsigned COL   = DEF_COL,
    parameter int unsigned DW    = DEF_DW,
    parameter int unsigned DEPTH = DEF_DEPTH
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              wr_vld,
    output logic                              wr_rdy,
    input  logic signed [COL*DW-1:0]          wr_data,
    input  logic                              rd_en,
    input  logic                              rd_mark,
    input  logic                              rd_rewind,
    input  logic                              rd_release,
    output logic signed [COL*DW-1:0]          ifm_buf,
    output logic                              buf_vld,
    output logic                              empty,
    output logic                              full,
    output logic [$clog2(DEPTH+1)-1:0]        count
);

    localparam int unsigned c_PW    = ptr_width(DEPTH);
    localparam int unsigned c_AW    = addr_width(DEPTH);
    localparam int unsigned c_CNT_W = $clog2(DEPTH+1);
    localparam int unsigned c_W     = COL * DW;

    logic [c_PW-1:0] r_wr_ptr;
    logic [c_PW-1:0] r_rd_ptr;
    logic [c_PW-1:0] r_base_ptr;
    logic            r_hold;
    logic [c_W-1:0]  r_buf;
    logic            r_buf_vld;

    logic [c_PW-1:0] w_count;
    logic            w_full;
    logic            w_empty;
    logic            w_wr_fire;
    logic            w_rewind;
    logic            w_mark;
    logic            w_pop;
    logic [c_PW-1:0] w_rd_next;
    logic [c_PW-1:0] w_base_next;
    logic            w_hold_next;
    logic [c_W-1:0]  w_rd_row;

    // Occupancy is measured from the window base so held rows stay counted.
    assign w_count   = r_wr_ptr - r_base_ptr;
    assign w_full    = (w_count == c_PW'(DEPTH));
    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    // Ready depends only on registered pointers, so a slot freed by a pop
    // becomes writable one cycle later.
    assign w_wr_fire = wr_vld && !w_full;

    // Resolve control priority and compute next read/base/hold state.
    always_comb begin
        w_rewind    = rd_rewind && !rd_release && r_hold;
        w_mark      = rd_mark && !rd_release && !rd_rewind;
        w_pop       = rd_en && !w_empty && !w_rewind;
        w_rd_next   = r_rd_ptr;
        w_base_next = r_base_ptr;
        w_hold_next = r_hold;
        if (w_rewind) begin
            w_rd_next = r_base_ptr;
        end else if (w_pop) begin
            w_rd_next = r_rd_ptr + c_PW'(1);
        end
        if (rd_release) begin
            w_hold_next = 1'b0;
            w_base_next = w_rd_next;
        end else if (w_rewind) begin
            w_base_next = r_base_ptr;
        end else if (w_mark) begin
            // Window starts at the row about to be popped, not after it.
            w_hold_next = 1'b1;
            w_base_next = r_rd_ptr;
        end else if (!r_hold) begin
            w_base_next = w_rd_next;
        end
    end

    // Pointer and window-state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_base_ptr <= '0;
            r_hold     <= 1'b0;
        end else begin
            if (w_wr_fire) begin
                r_wr_ptr <= r_wr_ptr + c_PW'(1);
            end
            r_rd_ptr   <= w_rd_next;
            r_base_ptr <= w_base_next;
            r_hold     <= w_hold_next;
        end
    end

    // Output row register: loads on a pop, otherwise holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_buf     <= '0;
            r_buf_vld <= 1'b0;
        end else begin
            r_buf_vld <= w_pop;
            if (w_pop) begin
                r_buf <= w_rd_row;
            end
        end
    end

    rf_ifm_mem #(
        .WIDTH (c_W),
        .DEPTH (DEPTH),
        .AW    (c_AW)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_wr_fire),
        .i_waddr (r_wr_ptr[c_AW-1:0]),
        .i_wdata (wr_data),
        .i_raddr (r_rd_ptr[c_AW-1:0]),
        .o_rdata (w_rd_row)
    );

    assign wr_rdy  = !w_full;
    assign full    = w_full;
    assign empty   = w_empty;
    assign count   = c_CNT_W'(w_count);
    assign ifm_buf = r_buf;
    assign buf_vld = r_buf_vld;

endmodule
`default_nettype wire

// File: tb/tb_rf_ifm_ring.sv
`default_nettype none
// ============================================================================
// Module   : tb_rf_ifm_ring
// Brief    : Self-checking bench for rf_ifm_ring with a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rf_ifm_ring;

    localparam int COL   = 8;
    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int W     = COL * DW;
    localparam int CW    = $clog2(DEPTH + 1);

    logic                clk = 1'b0;
    logic                rst;
    logic                wr_vld;
    logic                wr_rdy;
    logic signed [W-1:0] wr_data;
    logic                rd_en;
    logic                rd_mark;
    logic                rd_rewind;
    logic                rd_release;
    logic signed [W-1:0] ifm_buf;
    logic                buf_vld;
    logic                empty;
    logic                full;
    logic [CW-1:0]       count;

    rf_ifm_ring #(.COL(COL), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_vld     (wr_vld),
        .wr_rdy     (wr_rdy),
        .wr_data    (wr_data),
        .rd_en      (rd_en),
        .rd_mark    (rd_mark),
        .rd_rewind  (rd_rewind),
        .rd_release (rd_release),
        .ifm_buf    (ifm_buf),
        .buf_vld    (buf_vld),
        .empty      (empty),
        .full       (full),
        .count      (count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: retained rows in order (front = window base), read offset into
    // that list, hold flag, and expected output register.
    logic [W-1:0] mq[$];
    int           m_rd;
    bit           m_hold;
    logic [W-1:0] m_buf;
    bit           m_vld;
    bit           chk_en = 1'b0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_rd   = 0;
        m_hold = 1'b0;
        m_buf  = '0;
        m_vld  = 1'b0;
    endtask

    task automatic drop_front(input int n);
        for (int k = 0; k < n; k++) void'(mq.pop_front());
    endtask

    // Advance the model by one clock edge given the inputs presented to it.
    task automatic model_step(input bit wv, input logic [W-1:0] wd,
                              input bit re, input bit mk, input bit rw, input bit rl);
        bit m_full, m_empty, rew, mrk, pop;
        int old_rd;
        m_full  = (mq.size() == DEPTH);
        m_empty = (m_rd == mq.size());
        rew     = rw && !rl && m_hold;
        mrk     = mk && !rl && !rw;
        pop     = re && !m_empty && !rew;
        old_rd  = m_rd;
        m_vld   = pop;
        if (pop) begin
            m_buf = mq[m_rd];
            m_rd++;
        end
        if (wv && !m_full) mq.push_back(wd);
        if (rew) begin
            m_rd = 0;
        end else if (rl) begin
            m_hold = 1'b0;
            drop_front(m_rd);
            m_rd = 0;
        end else if (mrk) begin
            m_hold = 1'b1;
            drop_front(old_rd);
            m_rd = m_rd - old_rd;
        end else if (!m_hold) begin
            drop_front(m_rd);
            m_rd = 0;
        end
    endtask

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_ifm_buf", ifm_buf, m_buf);
            chk("cyc_buf_vld", W'(buf_vld), W'(m_vld));
            chk("cyc_empty",   W'(empty),   W'(m_rd == mq.size()));
            chk("cyc_full",    W'(full),    W'(mq.size() == DEPTH));
            chk("cyc_wr_rdy",  W'(wr_rdy),  W'(mq.size() != DEPTH));
            chk("cyc_count",   W'(count),   W'(mq.size()));
        end
    end

    task automatic step(input bit wv, input logic [W-1:0] wd,
                        input bit re, input bit mk, input bit rw, input bit rl);
        @(negedge clk);
        #1;
        wr_vld = wv; wr_data = wd; rd_en = re;
        rd_mark = mk; rd_rewind = rw; rd_release = rl;
        model_step(wv, wd, re, mk, rw, rl);
        @(posedge clk);
        #1;
        wr_vld = 0; rd_en = 0; rd_mark = 0; rd_rewind = 0; rd_release = 0;
    endtask

    task automatic wr(input logic [W-1:0] d); step(1, d, 0, 0, 0, 0); endtask
    task automatic pop();                     step(0, '0, 1, 0, 0, 0); endtask

    initial begin
        rst = 1'b1;
        wr_vld = 0; wr_data = '0; rd_en = 0;
        rd_mark = 0; rd_rewind = 0; rd_release = 0;
        model_reset();
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_buf",    ifm_buf,    64'h0);
        chk("rst_vld",    W'(buf_vld), 64'h0);
        chk("rst_empty",  W'(empty),  64'h1);
        chk("rst_full",   W'(full),   64'h0);
        chk("rst_count",  W'(count),  64'h0);
        chk("rst_wr_rdy", W'(wr_rdy), 64'h1);
        @(negedge clk);
        #1;
        rst = 1'b0;

        // In-order fill and drain.
        for (int i = 1; i <= 4; i++) wr(W'(i));
        for (int i = 1; i <= 4; i++) begin
            pop();
            chk("seq_buf", ifm_buf, W'(i));
            chk("seq_vld", W'(buf_vld), 64'h1);
        end
        chk("seq_empty", W'(empty), 64'h1);

        // Full, drop of the fifth row, and ready returning after a pop.
        for (int i = 0; i < 4; i++) wr(64'h11 + W'(i));
        chk("full_flag",  W'(full),   64'h1);
        chk("full_rdy",   W'(wr_rdy), 64'h0);
        wr(64'h15);
        chk("full_cnt",   W'(count),  64'h4);
        step(1, 64'h16, 1, 0, 0, 0);
        chk("full_pop",   ifm_buf,    64'h11);
        chk("full_rdy2",  W'(wr_rdy), 64'h1);
        chk("full_cnt2",  W'(count),  64'h3);
        pop(); pop(); pop();
        chk("full_last",  ifm_buf,    64'h14);
        chk("full_empty", W'(empty),  64'h1);

        // Mark, replay via rewind, release.
        wr(64'hA); wr(64'hB); wr(64'hC);
        step(0, '0, 0, 1, 0, 0);
        pop(); chk("win_a0", ifm_buf, 64'hA); chk("win_c0", W'(count), 64'h3);
        pop(); chk("win_b0", ifm_buf, 64'hB); chk("win_c1", W'(count), 64'h3);
        step(0, '0, 0, 0, 1, 0);
        chk("win_c2", W'(count), 64'h3);
        pop(); chk("win_a1", ifm_buf, 64'hA); chk("win_c3", W'(count), 64'h3);
        pop(); chk("win_b1", ifm_buf, 64'hB); chk("win_c4", W'(count), 64'h3);
        step(0, '0, 0, 0, 0, 1);
        chk("win_rel_cnt", W'(count), 64'h1);
        pop(); chk("win_c", ifm_buf, 64'hC);

        // Mark in the same cycle as a pop anchors at the pre-pop row.
        wr(64'h51); wr(64'h52);
        step(0, '0, 1, 1, 0, 0);
        chk("mkpop_buf", ifm_buf, 64'h51);
        chk("mkpop_cnt", W'(count), 64'h2);
        step(0, '0, 0, 0, 1, 0);
        pop(); chk("mkpop_replay", ifm_buf, 64'h51);
        step(0, '0, 0, 0, 0, 1);
        pop(); chk("mkpop_q", ifm_buf, 64'h52);

        // Window held full, release after two pops frees them.
        for (int i = 0; i < 4; i++) wr(64'hD0 + W'(i));
        step(0, '0, 0, 1, 0, 0);
        pop(); pop();
        chk("hold_full_cnt", W'(count),  64'h4);
        chk("hold_full_rdy", W'(wr_rdy), 64'h0);
        step(0, '0, 0, 0, 0, 1);
        chk("rel_cnt", W'(count),  64'h2);
        chk("rel_rdy", W'(wr_rdy), 64'h1);
        pop(); pop();

        // Pop + rewind + release together: release wins, pop proceeds.
        wr(64'hE0); wr(64'hE1); wr(64'hE2);
        step(0, '0, 0, 1, 0, 0);
        pop();
        step(0, '0, 1, 0, 1, 1);
        chk("prio_buf", ifm_buf, 64'hE1);
        chk("prio_vld", W'(buf_vld), 64'h1);
        chk("prio_cnt", W'(count), 64'h1);
        pop();

        // Reset in the middle of an open window.
        wr(64'hF0); wr(64'hF1); wr(64'hF2);
        step(0, '0, 0, 1, 0, 0);
        pop();
        @(negedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        chk("mrst_buf",   ifm_buf,   64'h0);
        chk("mrst_empty", W'(empty), 64'h1);
        chk("mrst_cnt",   W'(count), 64'h0);
        @(negedge clk);
        #1;
        rst = 1'b0;

        // Pointer wrap over several laps, including overlapped write+pop.
        for (int i = 0; i < 3 * DEPTH; i++) begin
            wr(64'h100 + W'(i));
            pop();
            chk("wrap_buf", ifm_buf, 64'h100 + W'(i));
        end
        wr(64'h200);
        for (int i = 1; i < 2 * DEPTH; i++) step(1, 64'h200 + W'(i), 1, 0, 0, 0);
        pop();
        chk("wrap_last", ifm_buf, 64'h200 + W'(2 * DEPTH - 1));
        chk("wrap_empty", W'(empty), 64'h1);

        @(negedge clk);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
